// File: rtl/led_pattern_pkg.sv
// Shared mode codes and bounce-direction constants for the LED pattern engine.
package led_pattern_pkg;

  localparam logic [2:0] MODE_OFF    = 3'd0;
  localparam logic [2:0] MODE_SHL    = 3'd1;
  localparam logic [2:0] MODE_SHR    = 3'd2;
  localparam logic [2:0] MODE_BOUNCE = 3'd3;
  localparam logic [2:0] MODE_BLINK  = 3'd4;
  localparam logic [2:0] MODE_COUNT  = 3'd5;
  localparam logic [2:0] MODE_ROTATE = 3'd6;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // The reserved code 7 behaves exactly like OFF.
  function automatic logic [2:0] decode_mode(input logic [2:0] m);
    logic [2:0] r;
    if (m == 3'd7) begin
      r = MODE_OFF;
    end else begin
      r = m;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_engine_tick_prescaler.sv
// Run-time programmable step prescaler: one tick every div_q+1 enabled cycles.
module tick_prescaler
  import led_pattern_pkg::*;
#(
  parameter int                RATE_W  = 24,
  parameter logic [RATE_W-1:0] DEF_DIV = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [RATE_W-1:0] div,
  output logic              tick
);

  logic [RATE_W-1:0] cnt_r;
  logic [RATE_W-1:0] div_r;

  // Combinational terminal-count flag consumed by the step logic on the same edge.
  assign tick = en & (cnt_r == div_r);

  // Period counter; a new divider is only adopted at the end of a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      div_r <= DEF_DIV;
    end else if (!en) begin
      cnt_r <= cnt_r;
      div_r <= div_r;
    end else if (restart) begin
      cnt_r <= '0;
      div_r <= div_r;
    end else if (cnt_r == div_r) begin
      cnt_r <= '0;
      div_r <= div;
    end else begin
      cnt_r <= cnt_r + RATE_W'(1);
      div_r <= div_r;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// Multi-mode LED pattern generator stepped by a run-time prescaler on the system clock.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int CLK_FREQ = 12090000,
  parameter int N_LED    = 8,
  parameter int RATE_W   = 24,
  parameter int DEF_DIV  = CLK_FREQ - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [RATE_W-1:0] div,
  input  logic              pat_load,
  input  logic [N_LED-1:0]  pat_in,
  output logic [N_LED-1:0]  led,
  output logic              step_tick
);

  logic [N_LED-1:0] led_r;
  logic             step_tick_r;
  logic [2:0]       mode_r;
  logic             dir_r;
  logic [N_LED-1:0] pat_r;

  logic             tick_s;
  logic             restart_s;
  logic             step_s;
  logic [2:0]       mode_req_s;
  logic [N_LED-1:0] seed_s;
  logic [N_LED-1:0] adv_s;
  logic             adv_dir_s;

  // Shift-based rotates stay well defined for N_LED=1 (both return the input).
  function automatic logic [N_LED-1:0] rotl(input logic [N_LED-1:0] x);
    return (x << 1) | (x >> (N_LED - 1));
  endfunction

  function automatic logic [N_LED-1:0] rotr(input logic [N_LED-1:0] x);
    return (x >> 1) | (x << (N_LED - 1));
  endfunction

  assign restart_s  = pat_load & en & (mode_r == MODE_ROTATE);
  assign step_s     = tick_s & ~pat_load;
  assign mode_req_s = decode_mode(mode);

  tick_prescaler #(
    .RATE_W  (RATE_W),
    .DEF_DIV (RATE_W'(DEF_DIV))
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .restart (restart_s),
    .div     (div),
    .tick    (tick_s)
  );

  // Seed loaded when the requested mode differs from the active one.
  always_comb begin
    seed_s = '0;
    case (mode_req_s)
      MODE_OFF:    seed_s = '0;
      MODE_SHL:    seed_s = N_LED'(1);
      MODE_SHR:    seed_s = N_LED'(1) << (N_LED - 1);
      MODE_BOUNCE: seed_s = N_LED'(1);
      MODE_BLINK:  seed_s = '1;
      MODE_COUNT:  seed_s = '0;
      MODE_ROTATE: seed_s = pat_r;
      default:     seed_s = '0;
    endcase
  end

  // Advance of the active pattern; bounce reverses when the lit bit hits either end.
  always_comb begin
    adv_s     = '0;
    adv_dir_s = dir_r;
    case (mode_r)
      MODE_OFF:    adv_s = '0;
      MODE_SHL:    adv_s = rotl(led_r);
      MODE_SHR:    adv_s = rotr(led_r);
      MODE_BOUNCE: begin
        if (N_LED == 1) begin
          adv_s = led_r;
        end else if (dir_r == DIR_UP) begin
          if (led_r[N_LED-1]) begin
            adv_s     = led_r >> 1;
            adv_dir_s = DIR_DN;
          end else begin
            adv_s = led_r << 1;
          end
        end else begin
          if (led_r[0]) begin
            adv_s     = led_r << 1;
            adv_dir_s = DIR_UP;
          end else begin
            adv_s = led_r >> 1;
          end
        end
      end
      MODE_BLINK:  adv_s = ~led_r;
      MODE_COUNT:  adv_s = led_r + N_LED'(1);
      MODE_ROTATE: adv_s = rotl(led_r);
      default:     adv_s = '0;
    endcase
  end

  // Pattern state; a pattern load in ROTATE pre-empts any coincident step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r       <= '0;
      step_tick_r <= 1'b0;
      mode_r      <= MODE_OFF;
      dir_r       <= DIR_UP;
      pat_r       <= '0;
    end else begin
      if (pat_load) begin
        pat_r <= pat_in;
      end else begin
        pat_r <= pat_r;
      end
      if (restart_s) begin
        led_r       <= pat_in;
        step_tick_r <= 1'b0;
      end else if (step_s) begin
        step_tick_r <= 1'b1;
        if (mode_req_s != mode_r) begin
          mode_r <= mode_req_s;
          led_r  <= seed_s;
          dir_r  <= DIR_UP;
        end else begin
          led_r <= adv_s;
          dir_r <= adv_dir_s;
        end
      end else begin
        step_tick_r <= 1'b0;
      end
    end
  end

  assign led       = led_r;
  assign step_tick = step_tick_r;

endmodule
